// File: rtl/aes_vector_sequencer_if.sv
// rtl/aes_vector_sequencer_if.sv - sequencer-to-AES-core stimulus/response bus
interface aes_vector_sequencer_if #(
    parameter int DATA_W = 128,
    parameter int KEY_W  = 128
);
    logic              AES_en;
    logic [DATA_W-1:0] AES_data_in;
    logic [KEY_W-1:0]  AES_key_in;
    logic [DATA_W-1:0] AES_data_out;
    logic              AES_data_out_valid;

    modport master (
        output AES_en,
        output AES_data_in,
        output AES_key_in,
        input  AES_data_out,
        input  AES_data_out_valid
    );

    modport slave (
        input  AES_en,
        input  AES_data_in,
        input  AES_key_in,
        output AES_data_out,
        output AES_data_out_valid
    );
endinterface

// File: rtl/aes_vector_sequencer.sv
// rtl/aes_vector_sequencer.sv - multi-vector AES stimulus, capture and check engine
module aes_vector_sequencer #(
    parameter int DATA_W  = 128,
    parameter int KEY_W   = 128,
    parameter int DEPTH   = 4,
    parameter int EN_HOLD = 51,
    parameter int TIMEOUT = 64,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    input  logic              cfg_wr_en,
    input  logic [IDX_W-1:0]  cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic [KEY_W-1:0]  cfg_wr_key,
    input  logic [DATA_W-1:0] cfg_wr_exp,
    input  logic              start,
    input  logic [IDX_W:0]    num_vec,
    input  logic              cmp_en,
    aes_vector_sequencer_if.master aes,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_idx,
    output logic [DATA_W-1:0] res_data,
    output logic              res_fail,
    output logic [IDX_W:0]    pass_cnt,
    output logic [IDX_W:0]    fail_cnt,
    output logic              timeout_err
);
    localparam int HOLD_W = $clog2(EN_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]    DEPTH_C   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]    CNT_ONE   = {{IDX_W{1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EN_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t r_state;

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [KEY_W-1:0]  r_mem_key  [DEPTH];
    logic [DATA_W-1:0] r_mem_exp  [DEPTH];

    logic              r_en;
    logic [DATA_W-1:0] r_data_in;
    logic [KEY_W-1:0]  r_key_in;
    logic              r_busy;
    logic              r_done;
    logic              r_res_valid;
    logic [IDX_W-1:0]  r_res_idx;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_fail;
    logic [IDX_W:0]    r_pass_cnt;
    logic [IDX_W:0]    r_fail_cnt;
    logic              r_tmo_err;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W:0]    r_n;
    logic              r_cmp;
    logic              r_captured;
    logic [HOLD_W-1:0] r_hold;
    logic [TMO_W-1:0]  r_tmo;

    logic              w_wr;
    logic [IDX_W:0]    w_n_eff;
    logic              w_cap;
    logic              w_mismatch;
    logic              w_last;
    logic [IDX_W-1:0]  w_next_idx;
    logic              w_fwd0;
    logic [DATA_W-1:0] w_slot0_data;
    logic [KEY_W-1:0]  w_slot0_key;

    assign w_wr       = cfg_wr_en && (r_state == S_IDLE);
    assign w_n_eff    = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;
    assign w_cap      = ((r_state == S_DRIVE) || (r_state == S_WAIT)) &&
                        aes.AES_data_out_valid && !r_captured;
    assign w_mismatch = r_cmp && (aes.AES_data_out != r_mem_exp[r_idx]);
    assign w_last     = (({1'b0, r_idx}) + CNT_ONE) == r_n;
    assign w_next_idx = r_idx + IDX_ONE;
    // A slot-0 write in the start cycle must be visible to the first vector.
    assign w_fwd0       = w_wr && (cfg_wr_addr == '0);
    assign w_slot0_data = w_fwd0 ? cfg_wr_data : r_mem_data[0];
    assign w_slot0_key  = w_fwd0 ? cfg_wr_key  : r_mem_key[0];

    assign aes.AES_en      = r_en;
    assign aes.AES_data_in = r_data_in;
    assign aes.AES_key_in  = r_key_in;
    assign busy            = r_busy;
    assign done            = r_done;
    assign res_valid       = r_res_valid;
    assign res_idx         = r_res_idx;
    assign res_data        = r_res_data;
    assign res_fail        = r_res_fail;
    assign pass_cnt        = r_pass_cnt;
    assign fail_cnt        = r_fail_cnt;
    assign timeout_err     = r_tmo_err;

    // Vector slot storage; survives reset so a self-test can be rerun.
    always_ff @(posedge AES_clk) begin
        if (w_wr) begin
            r_mem_data[cfg_wr_addr] <= cfg_wr_data;
            r_mem_key[cfg_wr_addr]  <= cfg_wr_key;
            r_mem_exp[cfg_wr_addr]  <= cfg_wr_exp;
        end
    end

    // Run sequencer: drive, wait, gap per vector, with capture and counting.
    always_ff @(posedge AES_clk) begin
        if (!AES_rst_n) begin
            r_state     <= S_IDLE;
            r_en        <= 1'b0;
            r_data_in   <= '0;
            r_key_in    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_data  <= '0;
            r_res_fail  <= 1'b0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_tmo_err   <= 1'b0;
            r_idx       <= '0;
            r_n         <= '0;
            r_cmp       <= 1'b0;
            r_captured  <= 1'b0;
            r_hold      <= '0;
            r_tmo       <= '0;
        end else begin
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;

            if (w_cap) begin
                r_captured  <= 1'b1;
                r_res_valid <= 1'b1;
                r_res_idx   <= r_idx;
                r_res_data  <= aes.AES_data_out;
                r_res_fail  <= w_mismatch;
                if (w_mismatch) begin
                    r_fail_cnt <= r_fail_cnt + CNT_ONE;
                end else begin
                    r_pass_cnt <= r_pass_cnt + CNT_ONE;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_n_eff == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_n        <= w_n_eff;
                            r_cmp      <= cmp_en;
                            r_idx      <= '0;
                            r_pass_cnt <= '0;
                            r_fail_cnt <= '0;
                            r_tmo_err  <= 1'b0;
                            r_busy     <= 1'b1;
                            r_en       <= 1'b1;
                            r_data_in  <= w_slot0_data;
                            r_key_in   <= w_slot0_key;
                            r_hold     <= '0;
                            r_captured <= 1'b0;
                            r_state    <= S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    if (r_hold == HOLD_LAST) begin
                        r_en <= 1'b0;
                        if (r_captured || w_cap) begin
                            r_state <= S_GAP;
                        end else begin
                            r_tmo   <= TMO_ONE;
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_ONE;
                    end
                end
                S_WAIT: begin
                    if (w_cap) begin
                        r_state <= S_GAP;
                    end else if (r_tmo == TMO_MAX) begin
                        r_captured  <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_res_idx   <= r_idx;
                        r_res_data  <= '0;
                        r_res_fail  <= 1'b1;
                        r_fail_cnt  <= r_fail_cnt + CNT_ONE;
                        r_tmo_err   <= 1'b1;
                        r_state     <= S_GAP;
                    end else begin
                        r_tmo <= r_tmo + TMO_ONE;
                    end
                end
                S_GAP: begin
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx      <= w_next_idx;
                        r_en       <= 1'b1;
                        r_data_in  <= r_mem_data[w_next_idx];
                        r_key_in   <= r_mem_key[w_next_idx];
                        r_hold     <= '0;
                        r_captured <= 1'b0;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_vector_sequencer.sv
// tb/tb_aes_vector_sequencer.sv - directed table-driven bench for aes_vector_sequencer
module tb_aes_vector_sequencer;
    localparam int DATA_W  = 128;
    localparam int KEY_W   = 128;
    localparam int DEPTH   = 4;
    localparam int EN_HOLD = 51;
    localparam int TIMEOUT = 64;
    localparam int IDX_W   = 2;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic              AES_clk = 1'b0;
    logic              AES_rst_n = 1'b0;
    logic              cfg_wr_en = 1'b0;
    logic [IDX_W-1:0]  cfg_wr_addr = '0;
    logic [DATA_W-1:0] cfg_wr_data = '0;
    logic [KEY_W-1:0]  cfg_wr_key = '0;
    logic [DATA_W-1:0] cfg_wr_exp = '0;
    logic              start = 1'b0;
    logic [IDX_W:0]    num_vec = '0;
    logic              cmp_en = 1'b0;
    logic              busy, done, res_valid, res_fail, timeout_err;
    logic [IDX_W-1:0]  res_idx;
    logic [DATA_W-1:0] res_data;
    logic [IDX_W:0]    pass_cnt, fail_cnt;

    aes_vector_sequencer_if #(.DATA_W(DATA_W), .KEY_W(KEY_W)) aes ();

    aes_vector_sequencer #(
        .DATA_W(DATA_W), .KEY_W(KEY_W), .DEPTH(DEPTH),
        .EN_HOLD(EN_HOLD), .TIMEOUT(TIMEOUT), .IDX_W(IDX_W)
    ) dut (
        .AES_clk(AES_clk), .AES_rst_n(AES_rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_wr_key(cfg_wr_key), .cfg_wr_exp(cfg_wr_exp),
        .start(start), .num_vec(num_vec), .cmp_en(cmp_en),
        .aes(aes.master),
        .busy(busy), .done(done), .res_valid(res_valid), .res_idx(res_idx),
        .res_data(res_data), .res_fail(res_fail), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .timeout_err(timeout_err)
    );

    always #5 AES_clk = ~AES_clk;

    int total = 0;
    int bad = 0;

    logic [127:0] sl_data [DEPTH];
    logic [127:0] sl_key  [DEPTH];
    logic [127:0] sl_exp  [DEPTH];

    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ k ^ 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Core model: fixed-latency response per AES_en rise, optional suppression/duplicate.
    int           core_lat = 10;
    bit           core_dup = 1'b0;
    logic [127:0] core_sup_pt = '1;
    bit           core_busy = 1'b0;
    bit           core_skip = 1'b0;
    int           core_cnt = 0;
    logic [127:0] core_res = '0;
    logic         core_en_q = 1'b0;
    always @(negedge AES_clk) begin
        aes.AES_data_out_valid = 1'b0;
        if (!AES_rst_n) begin
            core_busy = 1'b0;
            core_en_q = 1'b0;
        end else begin
            if (aes.AES_en && !core_en_q) begin
                core_busy = 1'b1;
                core_cnt  = 0;
                core_skip = (aes.AES_data_in == core_sup_pt);
                core_res  = core_fn(aes.AES_data_in, aes.AES_key_in);
            end
            if (core_busy) begin
                core_cnt++;
                if (!core_skip && (core_cnt == core_lat || (core_dup && core_cnt == core_lat + 2))) begin
                    aes.AES_data_out_valid = 1'b1;
                    aes.AES_data_out       = core_res;
                end
                if (core_cnt > core_lat + 2) core_busy = 1'b0;
            end
            core_en_q = aes.AES_en;
        end
    end

    // Cumulative monitor sampled 1 time unit after each rising edge.
    int           cyc = 0, en_cyc = 0, en_rise = 0, done_n = 0, busy_n = 0, fall_cyc = 0;
    logic         mon_en_q = 1'b0;
    int           q_idx [$];
    int           q_fail [$];
    int           q_dlt [$];
    logic [127:0] q_data [$];
    always @(posedge AES_clk) begin
        #1;
        cyc++;
        if (aes.AES_en === 1'b1) begin
            en_cyc++;
            if (!mon_en_q) en_rise++;
        end else if (mon_en_q) begin
            fall_cyc = cyc;
        end
        mon_en_q = (aes.AES_en === 1'b1);
        if (done === 1'b1) done_n++;
        if (busy === 1'b1) busy_n++;
        if (res_valid === 1'b1) begin
            q_idx.push_back(int'(res_idx));
            q_fail.push_back(int'(res_fail));
            q_data.push_back(res_data);
            q_dlt.push_back(cyc - fall_cyc);
        end
    end

    task automatic wr_slot(input logic [IDX_W-1:0] a, input logic [127:0] d,
                           input logic [127:0] k, input logic [127:0] e);
        @(negedge AES_clk);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d; cfg_wr_key = k; cfg_wr_exp = e;
        @(negedge AES_clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [IDX_W:0] nv, input logic ce);
        @(negedge AES_clk);
        num_vec = nv; cmp_en = ce; start = 1'b1;
        @(negedge AES_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_n == d0 && n < 3000) begin
            @(negedge AES_clk);
            n++;
        end
        total++;
        if (done_n == d0) begin
            bad++;
            $display("FAIL wait_done: no done pulse after %0d cycles", n);
        end
        repeat (4) @(negedge AES_clk);
    endtask

    typedef struct {
        logic [IDX_W:0] nv;
        logic           ce;
        int             sup;
        bit             dup;
        int             lat;
        int             n_res;
        logic [3:0]     fmask;
        int             pass;
        int             fail;
        logic           tmo;
    } row_t;

    row_t rows [8];

    initial begin
        int q0, e0, r0, d0, b0;
        logic [127:0] xd, xk;

        rows[0] = '{nv: 3'd1, ce: 1'b1, sup: -1, dup: 1'b0, lat: 10, n_res: 1, fmask: 4'b0000, pass: 1, fail: 0, tmo: 1'b0};
        rows[1] = '{nv: 3'd4, ce: 1'b1, sup: -1, dup: 1'b0, lat: 10, n_res: 4, fmask: 4'b0100, pass: 3, fail: 1, tmo: 1'b0};
        rows[2] = '{nv: 3'd4, ce: 1'b0, sup: -1, dup: 1'b0, lat: 10, n_res: 4, fmask: 4'b0000, pass: 4, fail: 0, tmo: 1'b0};
        rows[3] = '{nv: 3'd3, ce: 1'b1, sup: 1,  dup: 1'b0, lat: 10, n_res: 3, fmask: 4'b0110, pass: 1, fail: 2, tmo: 1'b1};
        rows[4] = '{nv: 3'd7, ce: 1'b1, sup: -1, dup: 1'b0, lat: 10, n_res: 4, fmask: 4'b0100, pass: 3, fail: 1, tmo: 1'b0};
        rows[5] = '{nv: 3'd2, ce: 1'b1, sup: -1, dup: 1'b1, lat: 10, n_res: 2, fmask: 4'b0000, pass: 2, fail: 0, tmo: 1'b0};
        rows[6] = '{nv: 3'd2, ce: 1'b1, sup: -1, dup: 1'b0, lat: 60, n_res: 2, fmask: 4'b0000, pass: 2, fail: 0, tmo: 1'b0};
        rows[7] = '{nv: 3'd0, ce: 1'b1, sup: -1, dup: 1'b0, lat: 10, n_res: 0, fmask: 4'b0000, pass: 2, fail: 0, tmo: 1'b0};

        sl_data[0] = FIPS_PT; sl_key[0] = FIPS_KEY; sl_exp[0] = FIPS_CT;
        for (int i = 1; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'h20 + 8'(i);
            sl_data[i] = {16{b}};
            b = 8'h70 + 8'(3 * i);
            sl_key[i]  = {16{b}};
            sl_exp[i]  = core_fn(sl_data[i], sl_key[i]);
        end
        sl_exp[2] = sl_exp[2] ^ 128'h1;

        repeat (3) @(negedge AES_clk);
        chk("rst_ctrl", {aes.AES_en, busy, done, res_valid, res_fail, timeout_err, pass_cnt, fail_cnt}, '0);
        chk("rst_data_in", aes.AES_data_in, '0);
        chk("rst_key_in", aes.AES_key_in, '0);
        AES_rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) wr_slot(IDX_W'(i), sl_data[i], sl_key[i], sl_exp[i]);

        for (int r = 0; r < 8; r++) begin
            q0 = q_idx.size(); e0 = en_cyc; r0 = en_rise; d0 = done_n; b0 = busy_n;
            core_lat = rows[r].lat;
            core_dup = rows[r].dup;
            core_sup_pt = (rows[r].sup >= 0) ? sl_data[rows[r].sup] : '1;
            start_run(rows[r].nv, rows[r].ce);
            wait_done(d0);
            chk($sformatf("r%0d_nres", r), q_idx.size() - q0, rows[r].n_res);
            for (int k = 0; k < rows[r].n_res; k++) begin
                if (q0 + k < q_idx.size()) begin
                    chk($sformatf("r%0d_k%0d_idx", r, k), q_idx[q0+k], k);
                    chk($sformatf("r%0d_k%0d_fail", r, k), q_fail[q0+k], rows[r].fmask[k]);
                    chk($sformatf("r%0d_k%0d_data", r, k), q_data[q0+k],
                        (rows[r].sup == k) ? 128'h0 : core_fn(sl_data[k], sl_key[k]));
                    if (rows[r].sup == k)
                        chk($sformatf("r%0d_k%0d_tmo_delay", r, k), q_dlt[q0+k], TIMEOUT);
                end
            end
            chk($sformatf("r%0d_pass", r), pass_cnt, rows[r].pass);
            chk($sformatf("r%0d_failc", r), fail_cnt, rows[r].fail);
            chk($sformatf("r%0d_tmo_err", r), timeout_err, rows[r].tmo);
            chk($sformatf("r%0d_done_n", r), done_n - d0, 1);
            chk($sformatf("r%0d_en_cyc", r), en_cyc - e0, EN_HOLD * rows[r].n_res);
            chk($sformatf("r%0d_en_rise", r), en_rise - r0, rows[r].n_res);
            chk($sformatf("r%0d_busy_seen", r), (busy_n - b0) > 0, rows[r].n_res > 0);
        end

        // Zero-length run: done in the very next cycle, never busy.
        @(negedge AES_clk);
        num_vec = '0; cmp_en = 1'b1; start = 1'b1;
        @(posedge AES_clk); #1;
        chk("nv0_done_next", {done, busy}, 2'b10);
        @(negedge AES_clk);
        start = 1'b0;
        @(posedge AES_clk); #1;
        chk("nv0_done_once", {done, busy}, 2'b00);
        core_lat = 10; core_dup = 1'b0; core_sup_pt = '1;

        // Slot write while busy must be dropped.
        d0 = done_n;
        start_run(3'd2, 1'b1);
        repeat (5) @(negedge AES_clk);
        wr_slot(2'd1, 128'hbad0bad0, 128'hbad1bad1, 128'hbad2bad2);
        wait_done(d0);
        q0 = q_idx.size(); d0 = done_n;
        start_run(3'd2, 1'b1);
        wait_done(d0);
        if (q_idx.size() >= q0 + 2)
            chk("busy_wr_slot1", q_data[q0+1], core_fn(sl_data[1], sl_key[1]));
        else
            chk("busy_wr_nres", q_idx.size() - q0, 2);
        chk("busy_wr_failc", fail_cnt, 0);

        // Write and start in the same cycle: the run sees the new slot 0.
        xd = 128'hdeadbeef_01234567_89abcdef_feedface;
        xk = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        q0 = q_idx.size(); d0 = done_n;
        @(negedge AES_clk);
        cfg_wr_en = 1'b1; cfg_wr_addr = 2'd0; cfg_wr_data = xd; cfg_wr_key = xk;
        cfg_wr_exp = core_fn(xd, xk); num_vec = 3'd1; cmp_en = 1'b1; start = 1'b1;
        @(negedge AES_clk);
        cfg_wr_en = 1'b0; start = 1'b0;
        chk("wrst_data_in", aes.AES_data_in, xd);
        chk("wrst_key_in", aes.AES_key_in, xk);
        wait_done(d0);
        if (q_idx.size() > q0) chk("wrst_res", q_data[q0], core_fn(xd, xk));
        chk("wrst_pass", {pass_cnt, fail_cnt}, {3'd1, 3'd0});
        wr_slot(2'd0, FIPS_PT, FIPS_KEY, FIPS_CT);

        // Reset during DRIVE of vector 1 aborts without a done pulse.
        r0 = en_rise; d0 = done_n;
        start_run(3'd4, 1'b1);
        for (int n = 0; n < 500 && (en_rise - r0) < 2; n++) @(negedge AES_clk);
        chk("mid_rst_reached_idx1", en_rise - r0, 2);
        repeat (3) @(negedge AES_clk);
        AES_rst_n = 1'b0;
        @(posedge AES_clk); #1;
        chk("mid_rst_ctrl", {aes.AES_en, busy, done, res_valid, res_fail, timeout_err, pass_cnt, fail_cnt, res_idx}, '0);
        chk("mid_rst_data", {aes.AES_data_in, res_data}, '0);
        chk("mid_rst_key", aes.AES_key_in, '0);
        @(negedge AES_clk);
        AES_rst_n = 1'b1;
        repeat (120) @(negedge AES_clk);
        chk("mid_rst_no_done", done_n - d0, 0);
        chk("mid_rst_idle", busy, 1'b0);
        q0 = q_idx.size(); e0 = en_cyc; d0 = done_n;
        start_run(3'd1, 1'b1);
        wait_done(d0);
        if (q_idx.size() > q0) chk("rerun_res", q_data[q0], FIPS_CT);
        else chk("rerun_nres", q_idx.size() - q0, 1);
        chk("rerun_cnt", {pass_cnt, fail_cnt}, {3'd1, 3'd0});
        chk("rerun_en_cyc", en_cyc - e0, EN_HOLD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish, got running want finished");
        $fatal(1);
    end
endmodule
